// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states, byte-enable patterns.
package mips_mem_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } state_e;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  // Big-endian lanes: offset 0 lives in bits [31:24], i.e. memBe[3].
  localparam logic [3:0] BeByte0  = 4'b1000;
  localparam logic [3:0] BeHalfHi = 4'b1100;
  localparam logic [3:0] BeHalfLo = 4'b0011;
  localparam logic [3:0] BeWord   = 4'b1111;

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SizeByte: be = BeByte0 >> off;
      SizeHalf: be = off[1] ? BeHalfLo : BeHalfHi;
      default:  be = BeWord;
    endcase
    return be;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SizeByte: mis = 1'b0;
      SizeHalf: mis = off[0];
      default:  mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Picks the addressed big-endian lane out of a read word and zero/sign-extends it.
module load_aligner
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        offset_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    unique case (offset_i)
      2'b00: byte_sel = rdata_i[31:24];
      2'b01: byte_sel = rdata_i[23:16];
      2'b10: byte_sel = rdata_i[15:8];
      2'b11: byte_sel = rdata_i[7:0];
    endcase
    half_sel = offset_i[1] ? rdata_i[15:0] : rdata_i[31:16];

    case (size_i)
      SizeByte: data_o = {{(DATA_W-8){signed_i & byte_sel[7]}}, byte_sel};
      SizeHalf: data_o = {{(DATA_W-16){signed_i & half_sel[15]}}, half_sel};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: branch resolve, req/ack data-memory access, registered MEM/WB outputs.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating.
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exValid,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] storeData,
  input  logic [DATA_W-1:0] addResult,
  input  logic              zero,
  input  logic              branch,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [1:0]        memSize,
  input  logic              loadSigned,
  input  logic              regWriteIn,
  input  logic [4:0]        writeRegIn,
  output logic              memReq,
  output logic              memWe,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  output logic [3:0]        memBe,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memRdata,
  output logic              stall,
  output logic              pcSrc,
  output logic [DATA_W-1:0] branchTarget,
  output logic              wbValid,
  output logic [DATA_W-1:0] wbData,
  output logic [4:0]        wbReg,
  output logic              wbRegWrite,
  output logic              busError
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  localparam int unsigned CntW = $clog2(MAX_WAIT);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              signed_q, signed_d;
  logic              regwr_q, regwr_d;
  logic [4:0]        reg_q, reg_d;

  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [4:0]        wb_reg_q, wb_reg_d;
  logic              wb_regwr_q, wb_regwr_d;
  logic              bus_error_q, bus_error_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              misalign_q, misalign_d;
  // Set for the cycle after a trap: the stalled instruction is still presented and must be dropped.
  logic              trap_q, trap_d;
`endif

  logic              stall_c;
  logic              mem_op;
  logic [1:0]        off_in;
  logic [DATA_W-1:0] wdata_in;
  logic [DATA_W-1:0] load_data;

  assign mem_op = memRead | memWrite;

  // Sub-word offsets are forced to natural alignment before lanes are chosen.
  always_comb begin
    case (memSize)
      SizeByte: begin
        off_in   = aluResult[1:0];
        wdata_in = {(DATA_W/8){storeData[7:0]}};
      end
      SizeHalf: begin
        off_in   = {aluResult[1], 1'b0};
        wdata_in = {(DATA_W/16){storeData[15:0]}};
      end
      default: begin
        off_in   = 2'b00;
        wdata_in = storeData;
      end
    endcase
  end

  load_aligner #(
    .DATA_W(DATA_W)
  ) u_load_aligner (
    .rdata_i (memRdata),
    .offset_i(off_q),
    .size_i  (size_q),
    .signed_i(signed_q),
    .data_o  (load_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_d       = alu_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    off_d       = off_q;
    size_d      = size_q;
    we_d        = we_q;
    signed_d    = signed_q;
    regwr_d     = regwr_q;
    reg_d       = reg_q;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    wb_reg_d    = wb_reg_q;
    wb_regwr_d  = wb_regwr_q;
    bus_error_d = 1'b0;
    stall_c     = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_d  = 1'b0;
    trap_d      = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
`ifdef MEM_MISALIGN_TRAP_EN
        if (trap_q) begin
          // Drop the held copy of the trapped instruction; upstream advances now.
        end else
`endif
        if (exValid && !mem_op) begin
          wb_valid_d = 1'b1;
          wb_data_d  = aluResult;
          wb_reg_d   = writeRegIn;
          wb_regwr_d = regWriteIn;
`ifdef MEM_MISALIGN_TRAP_EN
        end else if (exValid && is_misaligned(memSize, aluResult[1:0])) begin
          stall_c    = 1'b1;
          trap_d     = 1'b1;
          misalign_d = 1'b1;
          wb_valid_d = 1'b1;
          wb_data_d  = aluResult;
          wb_reg_d   = writeRegIn;
          wb_regwr_d = 1'b0;
`endif
        end else if (exValid) begin
          stall_c  = 1'b1;
          state_d  = StAccess;
          cnt_d    = '0;
          alu_d    = aluResult;
          wdata_d  = wdata_in;
          be_d     = byte_enables(memSize, off_in);
          off_d    = off_in;
          size_d   = memSize;
          we_d     = memWrite;
          signed_d = loadSigned;
          regwr_d  = regWriteIn & ~memWrite;
          reg_d    = writeRegIn;
        end
      end
      StAccess: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (memAck) begin
          stall_c    = 1'b0;
          state_d    = StIdle;
          wb_valid_d = 1'b1;
          wb_data_d  = we_q ? alu_q : load_data;
          wb_reg_d   = reg_q;
          wb_regwr_d = regwr_q;
        end else if (cnt_q == CntW'(MAX_WAIT - 1)) begin
          // The instruction retires with an error, so upstream is released here too.
          stall_c     = 1'b0;
          state_d     = StIdle;
          bus_error_d = 1'b1;
          wb_valid_d  = 1'b1;
          wb_data_d   = alu_q;
          wb_reg_d    = reg_q;
          wb_regwr_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      alu_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      off_q       <= '0;
      size_q      <= '0;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      regwr_q     <= 1'b0;
      reg_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_reg_q    <= '0;
      wb_regwr_q  <= 1'b0;
      bus_error_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
      trap_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_q       <= alu_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      off_q       <= off_d;
      size_q      <= size_d;
      we_q        <= we_d;
      signed_q    <= signed_d;
      regwr_q     <= regwr_d;
      reg_q       <= reg_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_reg_q    <= wb_reg_d;
      wb_regwr_q  <= wb_regwr_d;
      bus_error_q <= bus_error_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= misalign_d;
      trap_q      <= trap_d;
`endif
    end
  end

  // Bus fields are only driven while a request is open.
  assign memReq       = (state_q == StAccess);
  assign memWe        = memReq & we_q;
  assign memAddr      = memReq ? {alu_q[DATA_W-1:2], 2'b00} : '0;
  assign memWdata     = memReq ? wdata_q : '0;
  assign memBe        = memReq ? be_q : 4'b0000;
  assign stall        = stall_c & ~reset;
  assign pcSrc        = exValid & branch & zero & ~reset;
  assign branchTarget = addResult;
  assign wbValid      = wb_valid_q;
  assign wbData       = wb_data_q;
  assign wbReg        = wb_reg_q;
  assign wbRegWrite   = wb_regwr_q;
  assign busError     = bus_error_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign     = misalign_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed-vector bench for mem_access_stage with hand-computed expectations (MAX_WAIT = 8).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exValid = 1'b0;
  logic [31:0] aluResult = '0;
  logic [31:0] storeData = '0;
  logic [31:0] addResult = '0;
  logic        zero = 1'b0;
  logic        branch = 1'b0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [1:0]  memSize = 2'b00;
  logic        loadSigned = 1'b0;
  logic        regWriteIn = 1'b0;
  logic [4:0]  writeRegIn = '0;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memBe;
  logic        memAck = 1'b0;
  logic [31:0] memRdata = '0;
  logic        stall;
  logic        pcSrc;
  logic [31:0] branchTarget;
  logic        wbValid;
  logic [31:0] wbData;
  logic [4:0]  wbReg;
  logic        wbRegWrite;
  logic        busError;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic        obs_stall_idle, obs_req_idle, obs_req, obs_stall_wait, obs_stall_ack, obs_we;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata, obs_addr;

  mem_access_stage #(
    .DATA_W  (32),
    .MAX_WAIT(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .exValid     (exValid),
    .aluResult   (aluResult),
    .storeData   (storeData),
    .addResult   (addResult),
    .zero        (zero),
    .branch      (branch),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .memSize     (memSize),
    .loadSigned  (loadSigned),
    .regWriteIn  (regWriteIn),
    .writeRegIn  (writeRegIn),
    .memReq      (memReq),
    .memWe       (memWe),
    .memAddr     (memAddr),
    .memWdata    (memWdata),
    .memBe       (memBe),
    .memAck      (memAck),
    .memRdata    (memRdata),
    .stall       (stall),
    .pcSrc       (pcSrc),
    .branchTarget(branchTarget),
    .wbValid     (wbValid),
    .wbData      (wbData),
    .wbReg       (wbReg),
    .wbRegWrite  (wbRegWrite),
    .busError    (busError)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign    (misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_ex(input logic [31:0] alu, input logic [31:0] sd, input logic [1:0] size,
                          input logic rd, input logic wr, input logic sgn, input logic rw,
                          input logic [4:0] rg);
    exValid    = 1'b1;
    aluResult  = alu;
    storeData  = sd;
    memSize    = size;
    memRead    = rd;
    memWrite   = wr;
    loadSigned = sgn;
    regWriteIn = rw;
    writeRegIn = rg;
    branch     = 1'b0;
    zero       = 1'b0;
  endtask

  task automatic clear_ex();
    exValid    = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    memAck     = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;
    regWriteIn = 1'b0;
  endtask

  // Called just after EX was driven at a negedge; acks after wait_n idle ACCESS cycles.
  task automatic run_access(input int wait_n, input logic [31:0] rdata);
    #1;
    obs_stall_idle = stall;
    obs_req_idle   = memReq;
    @(posedge clk);
    #1 obs_req = memReq;
    obs_stall_wait = 1'b1;
    repeat (wait_n) begin
      @(negedge clk);
      #1 obs_stall_wait = obs_stall_wait & stall & memReq;
    end
    @(negedge clk);
    memAck   = 1'b1;
    memRdata = rdata;
    #1;
    obs_be        = memBe;
    obs_wdata     = memWdata;
    obs_we        = memWe;
    obs_addr      = memAddr;
    obs_stall_ack = stall;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_memReq", memReq, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wbValid", wbValid, 0);
    chk("rst_wbData", wbData, 0);
    chk("rst_busError", busError, 0);
    chk("rst_pcSrc", pcSrc, 0);
    @(negedge clk);
    reset = 1'b0;

    // ALU op passes straight to WB
    @(negedge clk);
    drive_ex(32'h12, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    #1 chk("alu_stall", stall, 0);
    @(posedge clk);
    #1;
    chk("alu_wbValid", wbValid, 1);
    chk("alu_wbData", wbData, 32'h12);
    chk("alu_wbReg", wbReg, 5);
    chk("alu_wbRegWrite", wbRegWrite, 1);
    @(negedge clk);
    clear_ex();
    @(posedge clk);
    #1 chk("alu_wbValid_pulse", wbValid, 0);

    // Branch resolution is same-cycle
    @(negedge clk);
    drive_ex(32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    branch    = 1'b1;
    zero      = 1'b1;
    addResult = 32'h40;
    #1;
    chk("br_taken_pcSrc", pcSrc, 1);
    chk("br_target", branchTarget, 32'h40);
    chk("br_stall", stall, 0);
    zero = 1'b0;
    #1 chk("br_not_taken_pcSrc", pcSrc, 0);
    @(negedge clk);
    clear_ex();

    // LW 0x100, ack in the fourth ACCESS cycle
    @(negedge clk);
    drive_ex(32'h100, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7);
    run_access(3, 32'hDEADBEEF);
    chk("lw_stall_idle", obs_stall_idle, 1);
    chk("lw_req_idle", obs_req_idle, 0);
    chk("lw_req", obs_req, 1);
    chk("lw_stall_held", obs_stall_wait, 1);
    chk("lw_stall_ack", obs_stall_ack, 0);
    chk("lw_addr", obs_addr, 32'h100);
    chk("lw_be", obs_be, 4'b1111);
    chk("lw_we", obs_we, 0);
    chk("lw_wbValid", wbValid, 1);
    chk("lw_wbData", wbData, 32'hDEADBEEF);
    chk("lw_wbReg", wbReg, 7);
    chk("lw_wbRegWrite", wbRegWrite, 1);
    chk("lw_req_drop", memReq, 0);
    @(negedge clk);
    clear_ex();

    // LB 0x103 signed then unsigned
    @(negedge clk);
    drive_ex(32'h103, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
    run_access(0, 32'h112233F0);
    chk("lbs_be", obs_be, 4'b0001);
    chk("lbs_addr", obs_addr, 32'h100);
    chk("lbs_wbData", wbData, 32'hFFFFFFF0);
    @(negedge clk);
    clear_ex();
    @(negedge clk);
    drive_ex(32'h103, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3);
    run_access(0, 32'h112233F0);
    chk("lbu_wbData", wbData, 32'h000000F0);
    @(negedge clk);
    clear_ex();

    // SH 0x102: low half lanes, replicated data, no register write
    @(negedge clk);
    drive_ex(32'h102, 32'hAABBCCDD, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4);
    run_access(0, 32'h0);
    chk("sh_be", obs_be, 4'b0011);
    chk("sh_wdata", obs_wdata, 32'hCCDDCCDD);
    chk("sh_we", obs_we, 1);
    chk("sh_addr", obs_addr, 32'h100);
    chk("sh_wbValid", wbValid, 1);
    chk("sh_wbRegWrite", wbRegWrite, 0);
    @(negedge clk);
    clear_ex();

    // SB 0x101
    @(negedge clk);
    drive_ex(32'h101, 32'hAABBCCDD, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    run_access(0, 32'h0);
    chk("sb_be", obs_be, 4'b0100);
    chk("sb_wdata", obs_wdata, 32'hDDDDDDDD);
    @(negedge clk);
    clear_ex();

`ifndef MEM_MISALIGN_TRAP_EN
    // Misaligned LH 0x103 truncates to offset 2 (low half)
    @(negedge clk);
    drive_ex(32'h103, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2);
    run_access(0, 32'h112233F0);
    chk("lh_trunc_be", obs_be, 4'b0011);
    chk("lh_trunc_addr", obs_addr, 32'h100);
    chk("lh_trunc_wbData", wbData, 32'h000033F0);
    @(negedge clk);
    clear_ex();
`endif

    // memAck while idle is ignored
    @(negedge clk);
    memAck = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ack_wbValid", wbValid, 0);
    chk("idle_ack_memReq", memReq, 0);
    @(negedge clk);
    memAck = 1'b0;

    // Timeout: busError after 8 ACCESS cycles
    @(negedge clk);
    drive_ex(32'h200, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9);
    @(posedge clk);
    #1 chk("to_req", memReq, 1);
    repeat (6) @(posedge clk);
    @(posedge clk);
    #1;
    chk("to_req_cycle8", memReq, 1);
    chk("to_no_err_yet", busError, 0);
    chk("to_no_wb_yet", wbValid, 0);
    @(posedge clk);
    #1;
    chk("to_busError", busError, 1);
    chk("to_wbValid", wbValid, 1);
    chk("to_wbRegWrite", wbRegWrite, 0);
    chk("to_req_drop", memReq, 0);
    @(negedge clk);
    clear_ex();
    @(posedge clk);
    #1 chk("to_busError_pulse", busError, 0);

    // Reset asserted mid-ACCESS
    @(negedge clk);
    drive_ex(32'h300, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1);
    @(posedge clk);
    #1 chk("ra_req", memReq, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ra_req_drop", memReq, 0);
    chk("ra_stall", stall, 0);
    clear_ex();
    @(posedge clk);
    #1 chk("ra_wbValid", wbValid, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ra_wbValid_after", wbValid, 0);
    chk("ra_req_after", memReq, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
